// File: rtl/imem_responder.sv
// imem_responder: in-order fixed-latency instruction memory with backpressure, flush and backdoor load
module imem_responder #(
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2,
  parameter int          OUTSTANDING = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic        o_rsp_err,
  input  logic        i_flush,
  input  logic        i_ld_en,
  input  logic [31:0] i_ld_addr,
  input  logic [31:0] i_ld_data
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int PW = OUTSTANDING > 1 ? $clog2(OUTSTANDING) : 1;
  localparam logic [2:0] LAT = 3'(LATENCY);
  localparam logic [2:0] OUT = 3'(OUTSTANDING);
  logic [31:0]      mem [DEPTH_WORDS];
  logic [31:0]      data_q [OUTSTANDING];
  logic             err_q [OUTSTANDING];
  logic [2:0]       age_q [OUTSTANDING];
  logic [OUTSTANDING-1:0] vld_q;
  logic [PW-1:0]    head, tail;
  logic [2:0]       cnt;
  logic [31:0]      req_off, ld_off;
  logic             req_err, ld_ok, push, pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(OUTSTANDING - 1) ? '0 : p + 1'b1;
  endfunction
  // address decode, handshakes and head presentation
  always_comb begin
    req_off     = i_req_addr - BASE_ADDR;
    ld_off      = i_ld_addr - BASE_ADDR;
    req_err     = (|req_off[1:0]) || (|req_off[31:AW+2]);
    ld_ok       = i_ld_en && !(|ld_off[1:0]) && !(|ld_off[31:AW+2]);
    o_req_ready = rst_n && !i_flush && (cnt < OUT);
    o_rsp_valid = (cnt != 3'd0) && (age_q[head] == LAT);
    o_rsp_data  = o_rsp_valid ? data_q[head] : 32'd0;
    o_rsp_err   = o_rsp_valid ? err_q[head] : 1'b0;
    push        = i_req_valid && o_req_ready;
    pop         = o_rsp_valid && i_rsp_ready && !i_flush;
  end
  // backdoor preload; array contents survive reset
  always_ff @(posedge clk)
    if (ld_ok) mem[ld_off[AW+1:2]] <= i_ld_data;
  // response queue: aging, push with array sample, pop, flush
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= 3'd0;
      vld_q <= '0;
      for (int i = 0; i < OUTSTANDING; i++) begin
        age_q[i]  <= 3'd0;
        data_q[i] <= 32'd0;
        err_q[i]  <= 1'b0;
      end
    end else if (i_flush) begin
      head  <= '0;
      tail  <= '0;
      cnt   <= 3'd0;
      vld_q <= '0;
      for (int i = 0; i < OUTSTANDING; i++) age_q[i] <= 3'd0;
    end else begin
      for (int i = 0; i < OUTSTANDING; i++)
        if (vld_q[i] && age_q[i] < LAT) age_q[i] <= age_q[i] + 3'd1;
      if (pop) begin
        vld_q[head] <= 1'b0;
        head        <= nxt(head);
      end
      if (push) begin
        vld_q[tail]  <= 1'b1;
        age_q[tail]  <= 3'd1;
        data_q[tail] <= req_err ? 32'd0 : mem[req_off[AW+1:2]];
        err_q[tail]  <= req_err;
        tail         <= nxt(tail);
      end
      cnt <= cnt + 3'(push) - 3'(pop);
    end
endmodule

// File: tb/tb_imem_responder.sv
// tb_imem_responder: directed and random checks against a timestamp-based response model
module tb_imem_responder;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;
  localparam int          OUT   = 2;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req_valid, o_req_ready, o_rsp_valid, i_rsp_ready, o_rsp_err;
  logic        i_flush, i_ld_en;
  logic [31:0] i_req_addr, o_rsp_data, i_ld_addr, i_ld_data;
  typedef struct {
    logic [31:0] d;
    logic        e;
    int          t;
  } ent_t;
  ent_t        q[$];
  logic [31:0] mem_m [DEPTH];
  logic [31:0] init_w [4];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic        last_v, last_rdy, last_e;
  logic [31:0] last_d;

  imem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT), .OUTSTANDING(OUT), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_addr(i_req_addr),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .i_flush(i_flush), .i_ld_en(i_ld_en), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rv, input logic [31:0] a, input logic rr, input logic fl,
                      input logic le, input logic [31:0] la, input logic [31:0] ld);
    logic        ev, er;
    logic [31:0] off;
    ent_t        e;
    i_req_valid = rv; i_req_addr = a; i_rsp_ready = rr; i_flush = fl;
    i_ld_en = le; i_ld_addr = la; i_ld_data = ld;
    #1;
    er = !fl && (q.size() < OUT);
    ev = (q.size() > 0) && (cyc >= q[0].t + LAT - 1);
    chk("req_ready", 32'(o_req_ready), 32'(er));
    chk("rsp_valid", 32'(o_rsp_valid), 32'(ev));
    chk("rsp_data", o_rsp_data, ev ? q[0].d : 32'd0);
    chk("rsp_err", 32'(o_rsp_err), ev ? 32'(q[0].e) : 32'd0);
    last_v = o_rsp_valid; last_rdy = o_req_ready; last_d = o_rsp_data; last_e = o_rsp_err;
    @(posedge clk);
    cyc++;
    if (fl) q.delete();
    else begin
      if (ev && rr) void'(q.pop_front());
      if (rv && er) begin
        off = a - BASE;
        e.e = (a[1:0] != 2'b00) || (off / 4 >= DEPTH);
        e.d = e.e ? 32'd0 : mem_m[off / 4];
        e.t = cyc;
        q.push_back(e);
      end
    end
    if (le) begin
      off = la - BASE;
      if (la[1:0] == 2'b00 && off / 4 < DEPTH) mem_m[off / 4] = ld;
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic req(input logic [31:0] a, input logic rr, input logic fl);
    step(1'b1, a, rr, fl, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic reset_now();
    rst_n = 1'b0;
    i_req_valid = 1'b0; i_req_addr = '0; i_rsp_ready = 1'b0; i_flush = 1'b0;
    i_ld_en = 1'b0; i_ld_addr = '0; i_ld_data = '0;
    #1;
    chk("rst_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_ready", 32'(o_req_ready), 32'd0);
    chk("rst_data", o_rsp_data, 32'd0);
    chk("rst_err", 32'(o_rsp_err), 32'd0);
    q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(o_req_ready), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] a, la;
    init_w[0] = 32'h0000_0013; init_w[1] = 32'h0010_0093;
    init_w[2] = 32'h0020_0113; init_w[3] = 32'h0030_0193;
    @(negedge clk);
    reset_now();
    for (int i = 0; i < 64; i++)
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1, BASE + 32'(4 * i), i < 4 ? init_w[i] : $urandom);
    req(BASE, 1'b1, 1'b0);
    idle(1);
    chk("lat_early", 32'(last_v), 32'd0);
    idle(1);
    chk("lat_valid", 32'(last_v), 32'd1);
    chk("lat_data", last_d, 32'h0000_0013);
    idle(1);
    req(BASE, 1'b0, 1'b0);
    req(BASE + 4, 1'b0, 1'b0);
    req(BASE + 8, 1'b0, 1'b0);
    chk("full_ready", 32'(last_rdy), 32'd0);
    req(BASE + 8, 1'b0, 1'b0);
    chk("hold_data", last_d, 32'h0000_0013);
    req(BASE + 8, 1'b1, 1'b0);
    chk("full_pop_ready", 32'(last_rdy), 32'd0);
    req(BASE + 8, 1'b0, 1'b0);
    chk("second_data", last_d, 32'h0010_0093);
    chk("third_accept", 32'(last_rdy), 32'd1);
    idle(4);
    req(BASE + 2, 1'b1, 1'b0);
    req(BASE + 32'(4 * DEPTH), 1'b1, 1'b0);
    idle(1);
    chk("misalign_err", 32'(last_e), 32'd1);
    idle(1);
    chk("range_err", 32'(last_e), 32'd1);
    chk("range_data", last_d, 32'd0);
    idle(2);
    req(BASE, 1'b0, 1'b0);
    req(BASE + 4, 1'b0, 1'b0);
    req(BASE + 12, 1'b0, 1'b1);
    chk("flush_ready", 32'(last_rdy), 32'd0);
    idle(1);
    chk("flush_gone", 32'(last_v), 32'd0);
    idle(2);
    req(BASE + 12, 1'b1, 1'b0);
    idle(1);
    idle(1);
    chk("refetch_data", last_d, 32'h0030_0193);
    idle(1);
    step(1'b1, BASE + 4, 1'b1, 1'b0, 1'b1, BASE + 4, 32'hDEAD_BEEF);
    req(BASE + 4, 1'b1, 1'b0);
    idle(1);
    chk("ld_old", last_d, 32'h0010_0093);
    idle(1);
    chk("ld_new", last_d, 32'hDEAD_BEEF);
    idle(2);
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0: a = BASE + 32'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
        1: a = BASE + 32'(4 * (DEPTH + $urandom_range(0, 15)));
        default: a = BASE + 32'(4 * $urandom_range(0, 63));
      endcase
      la = BASE + 32'(4 * $urandom_range(4, 70) + ($urandom_range(0, 5) == 0 ? 1 : 0));
      step($urandom_range(0, 3) != 0, a, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0,
           $urandom_range(0, 7) == 0, la, $urandom);
    end
    idle(4);
    req(BASE, 1'b0, 1'b0);
    req(BASE + 8, 1'b0, 1'b0);
    reset_now();
    idle(3);
    chk("no_stale", 32'(last_v), 32'd0);
    req(BASE, 1'b1, 1'b0);
    idle(1);
    idle(1);
    chk("retained", last_d, 32'h0000_0013);
    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
